memoria_instrucoes_carregavel: RTL and testbench

Parametrised, loadable instruction memory for the ReduxV core. It replaces the fixed, testbench-initialised instruction ROM with a synchronous RAM. A loader writes a program into it over a valid/ready stream, and the fetch stage then reads it with one-cycle registered latency. Fetches beyond the loaded program length return a NOP word and raise an error flag.

---
 rtl/memoria_instrucoes_carregavel.sv | 122 ++++++++++++
 tb/tb_memoria_instrucoes_carregavel.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_instrucoes_carregavel.sv
// Loadable instruction memory for the ReduxV core.
// A loader streams a program in over a valid/ready handshake, and the fetch
// stage then reads it back with one cycle of registered latency. Fetches at or
// beyond the loaded program length return NOP_WORD and raise addr_error.
module memoria_instrucoes_carregavel #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] position,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  output logic                  addr_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Count value held while the final array slot is being written.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                state_r;
  logic [DATA_WIDTH-1:0] rom_r [DEPTH];
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic                  in_range_s;

  // Write strobe and address; load_count doubles as the write pointer because
  // both clear on entry to LOAD and advance together on every accepted word.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = load_count[ADDR_WIDTH-1:0];
    in_range_s = ({1'b0, position} < load_count);
    if (state_r == ST_LOAD) begin
      wr_en_s = load_valid;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Program storage; deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      rom_r[wr_addr_s] <= load_data;
    end
  end

  // Control FSM with all outputs registered: load handshake, program length,
  // fetch data and the out-of-range flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      load_ready        <= 1'b0;
      load_done         <= 1'b0;
      load_count        <= {(ADDR_WIDTH + 1){1'b0}};
      instruction       <= NOP_WORD;
      instruction_valid <= 1'b0;
      addr_error        <= 1'b0;
    end else begin
      load_done         <= 1'b0;
      instruction_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_start) begin
            state_r    <= ST_LOAD;
            load_ready <= 1'b1;
            load_count <= {(ADDR_WIDTH + 1){1'b0}};
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            load_count <= load_count + (ADDR_WIDTH + 1)'(1);
            // The last-flagged word or the word filling the array ends the load.
            if (load_last || (load_count == LAST_IDX)) begin
              state_r    <= ST_RUN;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A fetch in the same cycle as a reload still sees the old program.
          if (fetch_en) begin
            instruction_valid <= 1'b1;
            if (in_range_s) begin
              instruction <= rom_r[position];
              addr_error  <= 1'b0;
            end else begin
              instruction <= NOP_WORD;
              addr_error  <= 1'b1;
            end
          end
          if (load_start) begin
            state_r    <= ST_LOAD;
            load_ready <= 1'b1;
            load_count <= {(ADDR_WIDTH + 1){1'b0}};
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          load_ready <= 1'b0;
          load_count <= {(ADDR_WIDTH + 1){1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_instrucoes_carregavel.sv
// Self-checking bench for memoria_instrucoes_carregavel. The reference model
// is simply the current program held as a queue: an in-range fetch returns
// the queued word, anything else returns NOP with the error flag set.
module tb_memoria_instrucoes_carregavel;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       load_done;
  logic [8:0] load_count;
  logic       fetch_en = 1'b0;
  logic [7:0] position = 8'h00;
  logic [7:0] instruction;
  logic       instruction_valid;
  logic       addr_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] prog[$];
  logic [7:0] last_instr = 8'h00;
  logic       last_err = 1'b0;

  memoria_instrucoes_carregavel dut (
    .clock             (clock),
    .reset             (reset),
    .load_start        (load_start),
    .load_valid        (load_valid),
    .load_data         (load_data),
    .load_last         (load_last),
    .load_ready        (load_ready),
    .load_done         (load_done),
    .load_count        (load_count),
    .fetch_en          (fetch_en),
    .position          (position),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .addr_error        (addr_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_one(input int p);
    logic [7:0] exp;
    fetch_en = 1'b1;
    position = p[7:0];
    step();
    if (p < prog.size()) exp = prog[p];
    else exp = 8'h00;
    chk("fetch_valid", {31'd0, instruction_valid}, 32'd1);
    chk("fetch_data", {24'd0, instruction}, {24'd0, exp});
    chk("fetch_err", {31'd0, addr_error}, (p >= prog.size()) ? 32'd1 : 32'd0);
    last_instr = exp;
    last_err = (p >= prog.size());
  endtask

  task automatic idle_one();
    fetch_en = 1'b0;
    step();
    chk("idle_valid", {31'd0, instruction_valid}, 32'd0);
    chk("idle_hold", {24'd0, instruction}, {24'd0, last_instr});
    chk("idle_err", {31'd0, addr_error}, {31'd0, last_err});
  endtask

  task automatic start_load();
    load_start = 1'b1;
    fetch_en = 1'b0;
    step();
    load_start = 1'b0;
    chk("start_ready", {31'd0, load_ready}, 32'd1);
    chk("start_count", {23'd0, load_count}, 32'd0);
  endtask

  // Streams n random words; fetch_en toggles randomly and must be ignored.
  task automatic feed(input int n, input bit use_last, input bit gaps);
    logic [7:0] q[$];
    int dones = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && (i % 5) == 0) begin
        for (int g = 0; g < 3; g++) begin
          load_valid = 1'b0;
          step();
          chk("gap_count", {23'd0, load_count}, i);
          chk("gap_ready", {31'd0, load_ready}, 32'd1);
          dones += int'(load_done);
        end
      end
      load_valid = 1'b1;
      load_data = 8'($urandom);
      load_last = use_last && (i == n - 1);
      fetch_en = 1'($urandom);
      position = 8'($urandom);
      step();
      q.push_back(load_data);
      dones += int'(load_done);
      chk("load_no_fetch", {31'd0, instruction_valid}, 32'd0);
      chk("load_hold", {24'd0, instruction}, {24'd0, last_instr});
      chk("load_count", {23'd0, load_count}, i + 1);
      chk("load_done", {31'd0, load_done}, (i == n - 1) ? 32'd1 : 32'd0);
      chk("load_ready", {31'd0, load_ready}, (i == n - 1) ? 32'd0 : 32'd1);
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    fetch_en = 1'b0;
    step();
    dones += int'(load_done);
    chk("done_pulses", dones, 32'd1);
    chk("final_count", {23'd0, load_count}, n);
    prog = q;
  endtask

  initial begin
    // Reset values
    repeat (2) step();
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_count", {23'd0, load_count}, 32'd0);
    chk("rst_instr", {24'd0, instruction}, 32'd0);
    chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
    chk("rst_err", {31'd0, addr_error}, 32'd0);
    reset = 1'b0;
    fetch_en = 1'b1;
    position = 8'd0;
    step();
    chk("idle_fetch_ignored", {31'd0, instruction_valid}, 32'd0);
    load_valid = 1'b1;
    fetch_en = 1'b0;
    step();
    load_valid = 1'b0;
    chk("idle_load_ignored", {23'd0, load_count}, 32'd0);
    chk("idle_ready", {31'd0, load_ready}, 32'd0);

    // 35-word program and back-to-back fetch of all of it
    start_load();
    feed(35, 1'b1, 1'b0);
    for (int p = 0; p < 35; p++) fetch_one(p);
    // Out of range, then recovery
    fetch_one(35);
    fetch_one(255);
    fetch_one(0);
    idle_one();
    // Random fetch/idle mix
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) != 0) fetch_one($urandom_range(0, 255));
      else idle_one();
    end

    // Full array with gaps, no load_last
    start_load();
    feed(256, 1'b0, 1'b1);
    fetch_one(255);
    fetch_one(0);
    for (int k = 0; k < 20; k++) fetch_one($urandom_range(0, 255));
    idle_one();

    // Reset in the middle of a load
    start_load();
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data = 8'($urandom);
      step();
    end
    chk("mid_count", {23'd0, load_count}, 32'd10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_valid = 1'b0;
    prog.delete();
    last_instr = 8'h00;
    last_err = 1'b0;
    chk("midrst_count", {23'd0, load_count}, 32'd0);
    chk("midrst_done", {31'd0, load_done}, 32'd0);
    chk("midrst_ready", {31'd0, load_ready}, 32'd0);
    chk("midrst_instr", {24'd0, instruction}, 32'd0);
    fetch_en = 1'b1;
    position = 8'd0;
    step();
    fetch_en = 1'b0;
    chk("midrst_idle_fetch", {31'd0, instruction_valid}, 32'd0);
    start_load();
    feed(4, 1'b1, 1'b0);
    for (int p = 0; p < 12; p++) fetch_one(p);

    // Reload from RUN with a simultaneous fetch of the old word 2
    load_start = 1'b1;
    fetch_en = 1'b1;
    position = 8'd2;
    step();
    load_start = 1'b0;
    fetch_en = 1'b0;
    chk("reload_valid", {31'd0, instruction_valid}, 32'd1);
    chk("reload_old_word", {24'd0, instruction}, {24'd0, prog[2]});
    chk("reload_err", {31'd0, addr_error}, 32'd0);
    chk("reload_ready", {31'd0, load_ready}, 32'd1);
    chk("reload_count", {23'd0, load_count}, 32'd0);
    last_instr = prog[2];
    last_err = 1'b0;
    feed(7, 1'b1, 1'b0);
    for (int p = 0; p < 9; p++) fetch_one(p);
    idle_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
